// File: rtl/genetic_eval_ctrl.sv
// Sequencer for the combinational genetic circuit evaluator: serial chromosome load, input
// sweep, and fitness accumulation. Define GENETIC_FIRST_FAIL_EN to add first_fail/fail_valid.
module genetic_eval_ctrl #(
    parameter int unsigned IN      = 4,
    parameter int unsigned OUT     = 2,
    parameter int unsigned CHROM_W = 50,
    parameter int unsigned SETTLE  = 1,
    parameter int unsigned FIT_W   = $clog2(OUT * 2**IN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  reload,
    input  logic                  chrom_bit,
    input  logic                  chrom_bit_valid,
    input  logic [OUT*2**IN-1:0]  target,
    input  logic [OUT-1:0]        eval_out,
    output logic [CHROM_W-1:0]    cromossomo,
    output logic [IN-1:0]         inp,
    output logic                  busy,
    output logic                  done,
    output logic [FIT_W-1:0]      fitness
`ifdef GENETIC_FIRST_FAIL_EN
    ,
    output logic [IN-1:0]         first_fail,
    output logic                  fail_valid
`endif
);

    localparam int unsigned NVEC = 2**IN;
    localparam int unsigned LW   = (CHROM_W > 1) ? $clog2(CHROM_W) : 1;
    localparam int unsigned SW   = $clog2(SETTLE + 1);

    localparam logic [LW-1:0] LoadLast  = LW'(CHROM_W - 1);
    localparam logic [SW-1:0] SettleMax = SW'(SETTLE);
    localparam logic [IN-1:0] VecLast   = IN'(NVEC - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StEval, StFinish} state_e;

    state_e               state_q, state_d;
    logic [CHROM_W-1:0]   crom_q, crom_d;
    logic [IN-1:0]        inp_q, inp_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [FIT_W-1:0]     fitness_q, fitness_d;
    logic [FIT_W-1:0]     acc_q, acc_d;
    logic [LW-1:0]        load_cnt_q, load_cnt_d;
    logic [SW-1:0]        settle_q, settle_d;

    logic [OUT-1:0]       tgt_slice;
    logic [OUT-1:0]       match_bits;
    logic [FIT_W-1:0]     match_cnt;

`ifdef GENETIC_FIRST_FAIL_EN
    logic [IN-1:0]        ff_acc_q, ff_acc_d;
    logic                 fv_acc_q, fv_acc_d;
    logic [IN-1:0]        first_fail_q, first_fail_d;
    logic                 fail_valid_q, fail_valid_d;
`endif

    // Expected output bits for the vector currently driven on inp.
    always_comb begin
        tgt_slice = '0;
        for (int v = 0; v < NVEC; v++) begin
            if (inp_q == IN'(v)) begin
                tgt_slice = target[v*OUT +: OUT];
            end
        end
        match_bits = ~(eval_out ^ tgt_slice);
        match_cnt  = '0;
        for (int i = 0; i < OUT; i++) begin
            match_cnt = match_cnt + FIT_W'(match_bits[i]);
        end
    end

    always_comb begin
        state_d    = state_q;
        crom_d     = crom_q;
        inp_d      = inp_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        fitness_d  = fitness_q;
        acc_d      = acc_q;
        load_cnt_d = load_cnt_q;
        settle_d   = settle_q;
`ifdef GENETIC_FIRST_FAIL_EN
        ff_acc_d     = ff_acc_q;
        fv_acc_d     = fv_acc_q;
        first_fail_d = first_fail_q;
        fail_valid_d = fail_valid_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    busy_d   = 1'b1;
                    acc_d    = '0;
                    settle_d = '0;
`ifdef GENETIC_FIRST_FAIL_EN
                    ff_acc_d = '0;
                    fv_acc_d = 1'b0;
`endif
                    if (reload) begin
                        state_d    = StLoad;
                        load_cnt_d = '0;
                    end else begin
                        state_d = StEval;
                        inp_d   = '0;
                    end
                end
            end

            StLoad: begin
                if (chrom_bit_valid) begin
                    crom_d = {crom_q[CHROM_W-2:0], chrom_bit};
                    if (load_cnt_q == LoadLast) begin
                        state_d  = StEval;
                        inp_d    = '0;
                        settle_d = '0;
                    end else begin
                        load_cnt_d = load_cnt_q + LW'(1);
                    end
                end
            end

            StEval: begin
                if (settle_q == SettleMax) begin
                    acc_d    = acc_q + match_cnt;
                    settle_d = '0;
`ifdef GENETIC_FIRST_FAIL_EN
                    // Only the lowest failing vector is kept; the sweep runs upwards.
                    if (!fv_acc_q && (match_bits != {OUT{1'b1}})) begin
                        ff_acc_d = inp_q;
                        fv_acc_d = 1'b1;
                    end
`endif
                    if (inp_q == VecLast) begin
                        state_d = StFinish;
                    end else begin
                        inp_d = inp_q + IN'(1);
                    end
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end

            StFinish: begin
                fitness_d = acc_q;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = StIdle;
`ifdef GENETIC_FIRST_FAIL_EN
                first_fail_d = ff_acc_q;
                fail_valid_d = fv_acc_q;
`endif
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            crom_q     <= '0;
            inp_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fitness_q  <= '0;
            acc_q      <= '0;
            load_cnt_q <= '0;
            settle_q   <= '0;
`ifdef GENETIC_FIRST_FAIL_EN
            ff_acc_q     <= '0;
            fv_acc_q     <= 1'b0;
            first_fail_q <= '0;
            fail_valid_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            crom_q     <= crom_d;
            inp_q      <= inp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fitness_q  <= fitness_d;
            acc_q      <= acc_d;
            load_cnt_q <= load_cnt_d;
            settle_q   <= settle_d;
`ifdef GENETIC_FIRST_FAIL_EN
            ff_acc_q     <= ff_acc_d;
            fv_acc_q     <= fv_acc_d;
            first_fail_q <= first_fail_d;
            fail_valid_q <= fail_valid_d;
`endif
        end
    end

    assign cromossomo = crom_q;
    assign inp        = inp_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fitness    = fitness_q;
`ifdef GENETIC_FIRST_FAIL_EN
    assign first_fail = first_fail_q;
    assign fail_valid = fail_valid_q;
`endif

endmodule

// File: tb/tb_genetic_eval_ctrl.sv
// Directed bench for genetic_eval_ctrl at default parameters, with a stub evaluator
// (eval_out = inp[1:0]) and hand-computed fitness and latency expectations.
module tb_genetic_eval_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        reload;
    logic        chrom_bit;
    logic        chrom_bit_valid;
    logic [31:0] target;
    logic [1:0]  eval_out;
    logic [49:0] cromossomo;
    logic [3:0]  inp;
    logic        busy;
    logic        done;
    logic [5:0]  fitness;
`ifdef GENETIC_FIRST_FAIL_EN
    logic [3:0]  first_fail;
    logic        fail_valid;
`endif

    int checks = 0;
    int errors = 0;

    logic [49:0] pat;
    logic [31:0] tgt_perfect;

    genetic_eval_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .reload          (reload),
        .chrom_bit       (chrom_bit),
        .chrom_bit_valid (chrom_bit_valid),
        .target          (target),
        .eval_out        (eval_out),
        .cromossomo      (cromossomo),
        .inp             (inp),
        .busy            (busy),
        .done            (done),
        .fitness         (fitness)
`ifdef GENETIC_FIRST_FAIL_EN
        ,
        .first_fail      (first_fail),
        .fail_valid      (fail_valid)
`endif
    );

    assign eval_out = inp[1:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until done is seen or the budget runs out; caller compares the cycle count.
    task automatic wait_done(input int limit, inout int cycles);
        while (!done && cycles < limit) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            start           = 1'($urandom);
            reload          = 1'($urandom);
            chrom_bit       = 1'($urandom);
            chrom_bit_valid = 1'($urandom);
            target          = $urandom;
            tick();
        end
        checks++; if (cromossomo !== 50'd0) begin errors++; $display("FAIL reset_crom: got %h expected 0", cromossomo); end
        checks++; if (inp !== 4'd0) begin errors++; $display("FAIL reset_inp: got %0d expected 0", inp); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (fitness !== 6'd0) begin errors++; $display("FAIL reset_fitness: got %0d expected 0", fitness); end
        rst             = 1'b0;
        start           = 1'b0;
        reload          = 1'b0;
        chrom_bit_valid = 1'b0;
        chrom_bit       = 1'b0;
    endtask

    task automatic test_full_load();
        int cycles;
        target = tgt_perfect;
        start  = 1'b1;
        reload = 1'b1;
        tick();
        start  = 1'b0;
        cycles = 0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy: got %b expected 1", busy); end
        for (int i = 0; i < 50; i++) begin
            chrom_bit       = pat[49-i];
            chrom_bit_valid = 1'b1;
            tick();
            cycles++;
        end
        chrom_bit_valid = 1'b0;
        wait_done(200, cycles);
        checks++; if (cycles !== 83) begin errors++; $display("FAIL load_latency: got %0d expected 83", cycles); end
        checks++; if (cromossomo !== pat) begin errors++; $display("FAIL load_crom: got %h expected %h", cromossomo, pat); end
        checks++; if (fitness !== 6'd32) begin errors++; $display("FAIL load_fitness: got %0d expected 32", fitness); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_busy_end: got %b expected 0", busy); end
        checks++; if (inp !== 4'd15) begin errors++; $display("FAIL load_inp_hold: got %0d expected 15", inp); end
    endtask

    // Starts in the very cycle done is high, so this also covers start right after done.
    task automatic test_inverted_rerun();
        int cycles;
        target = ~tgt_perfect;
        start  = 1'b1;
        reload = 1'b0;
        tick();
        start  = 1'b0;
        cycles = 0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rerun_done_pulse: got %b expected 0", done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rerun_accept: got %b expected 1", busy); end
        wait_done(100, cycles);
        checks++; if (cycles !== 33) begin errors++; $display("FAIL rerun_latency: got %0d expected 33", cycles); end
        checks++; if (fitness !== 6'd0) begin errors++; $display("FAIL rerun_fitness: got %0d expected 0", fitness); end
        checks++; if (cromossomo !== pat) begin errors++; $display("FAIL rerun_crom: got %h expected %h", cromossomo, pat); end
        tick();
    endtask

    task automatic test_stalls_dropped_start();
        int cycles;
        int done_cnt;
        int done_cyc;
        logic [49:0] pat2;
        pat2     = ~pat;
        target   = tgt_perfect;
        start    = 1'b1;
        reload   = 1'b1;
        tick();
        start    = 1'b0;
        cycles   = 0;
        done_cnt = 0;
        done_cyc = -1;
        for (int i = 0; i < 50; i++) begin
            chrom_bit       = 1'($urandom);
            chrom_bit_valid = 1'b0;
            tick();
            cycles++;
            chrom_bit       = pat2[49-i];
            chrom_bit_valid = 1'b1;
            tick();
            cycles++;
        end
        chrom_bit_valid = 1'b0;
        checks++; if (cromossomo !== pat2) begin errors++; $display("FAIL stall_crom: got %h expected %h", cromossomo, pat2); end
        while (cycles < 150) begin
            start  = (cycles == 104);
            reload = 1'b1;
            tick();
            cycles++;
            if (done) begin
                done_cnt++;
                done_cyc = cycles;
            end
        end
        start = 1'b0;
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL stall_done_count: got %0d expected 1", done_cnt); end
        checks++; if (done_cyc !== 133) begin errors++; $display("FAIL stall_latency: got %0d expected 133", done_cyc); end
        checks++; if (fitness !== 6'd32) begin errors++; $display("FAIL stall_fitness: got %0d expected 32", fitness); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_start_dropped: got %b expected 0", busy); end
    endtask

    task automatic test_mid_reset();
        int cycles;
        int done_cnt;
        target = tgt_perfect;
        start  = 1'b1;
        reload = 1'b0;
        tick();
        start  = 1'b0;
        repeat (14) tick();
        checks++; if (inp !== 4'd7) begin errors++; $display("FAIL midrst_inp_before: got %0d expected 7", inp); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (inp !== 4'd0) begin errors++; $display("FAIL midrst_inp: got %0d expected 0", inp); end
        checks++; if (fitness !== 6'd0) begin errors++; $display("FAIL midrst_fitness: got %0d expected 0", fitness); end
        checks++; if (cromossomo !== 50'd0) begin errors++; $display("FAIL midrst_crom: got %h expected 0", cromossomo); end
        done_cnt = 0;
        repeat (40) begin
            if (done) done_cnt++;
            tick();
        end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", done_cnt); end
        start  = 1'b1;
        reload = 1'b0;
        tick();
        start  = 1'b0;
        cycles = 0;
        wait_done(100, cycles);
        checks++; if (cycles !== 33) begin errors++; $display("FAIL midrst_rerun_latency: got %0d expected 33", cycles); end
        checks++; if (fitness !== 6'd32) begin errors++; $display("FAIL midrst_rerun_fitness: got %0d expected 32", fitness); end
`ifdef GENETIC_FIRST_FAIL_EN
        checks++; if (fail_valid !== 1'b0) begin errors++; $display("FAIL perfect_fail_valid: got %b expected 0", fail_valid); end
`endif
        tick();
    endtask

    task automatic test_first_fail();
        int cycles;
        logic [31:0] t;
        t      = tgt_perfect;
        t[10]  = ~t[10];
        t[20]  = ~t[20];
        target = t;
        start  = 1'b1;
        reload = 1'b0;
        tick();
        start  = 1'b0;
        cycles = 0;
        wait_done(100, cycles);
        checks++; if (cycles !== 33) begin errors++; $display("FAIL ff_latency: got %0d expected 33", cycles); end
        checks++; if (fitness !== 6'd30) begin errors++; $display("FAIL ff_fitness: got %0d expected 30", fitness); end
`ifdef GENETIC_FIRST_FAIL_EN
        checks++; if (first_fail !== 4'd5) begin errors++; $display("FAIL ff_first_fail: got %0d expected 5", first_fail); end
        checks++; if (fail_valid !== 1'b1) begin errors++; $display("FAIL ff_fail_valid: got %b expected 1", fail_valid); end
`endif
        tick();
    endtask

    initial begin
        rst             = 1'b1;
        start           = 1'b0;
        reload          = 1'b0;
        chrom_bit       = 1'b0;
        chrom_bit_valid = 1'b0;
        target          = '0;
        pat             = 50'b01111101100011000001011110010000101000111101011010;
        for (int v = 0; v < 16; v++) begin
            tgt_perfect[v*2 +: 2] = 2'(v);
        end

        test_reset();
        test_full_load();
        test_inverted_rerun();
        test_stalls_dropped_start();
        test_mid_reset();
        test_first_fail();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
